obstacle_spawner: RTL and testbench

Generates obstacle spawn commands for the downstream obstacle controller: decides when a new obstacle enters the screen, which lane it starts in and which type it is, and issues a one-cycle `obstacle_trigger` pulse with a matching `obstacle_start_x`. It sits between the game-state logic (enable, frame tick) and the obstacle controller, and paces spawns per frame with a cooldown that shortens as more obstacles are spawned.

---
 rtl/obstacle_spawner.sv | 147 ++++++++++++++
 tb/tb_obstacle_spawner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// Obstacle spawn pacing: per-frame cooldown, LFSR-driven lane/type pick, and a
// one-cycle typed trigger with its start x for the obstacle controller.
module obstacle_spawner #(
  parameter int          NUM_LANES       = 5,
  parameter int          LANE_PITCH      = 128,
  parameter int          LANE_OFFSET     = 48,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter int          MIN_COOLDOWN    = 15,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       obstacle_active,
  output logic [1:0] obstacle_trigger,
  output logic [9:0] obstacle_start_x,
  output logic [7:0] spawn_count
);

  typedef enum logic [1:0] {IDLE, COOLDOWN, PICK, FIRE} state_t;

  // An all-zero seed would lock the LFSR, so fall back to 1 in that case.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  LANES_W   = 4'(NUM_LANES);

  state_t      state;
  state_t      next_state;
  logic [15:0] lfsr;
  logic [7:0]  cd_cnt;
  logic [2:0]  lane;
  logic [1:0]  typ;
  logic        lane_ok;
  logic [9:0]  lane_x;
  logic [7:0]  reload;
  logic        load_cd;
  logic        dec_cd;
  logic        fire_go;
  logic        count_inc;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cur);
    return (cur == 8'hFF) ? cur : cur + 8'd1;
  endfunction

  // Difficulty ramp: one frame shorter every four spawns, clamped at the floor.
  function automatic logic [7:0] reload_value(input logic [7:0] cnt);
    logic signed [8:0] base;
    logic signed [8:0] step;
    logic signed [8:0] floor_v;
    logic signed [8:0] raw;
    base    = 9'(COOLDOWN_FRAMES);
    step    = {3'b000, cnt[7:2]};
    floor_v = 9'(MIN_COOLDOWN);
    raw     = base - step;
    if (raw < floor_v) begin
      raw = floor_v;
    end
    return raw[7:0];
  endfunction

  assign lane    = lfsr[2:0];
  assign typ     = (lfsr[4:3] == 2'd0) ? 2'd1 : lfsr[4:3];
  assign lane_ok = ({1'b0, lane} < LANES_W);
  assign lane_x  = 10'(LANE_OFFSET) + 10'(lane) * 10'(LANE_PITCH);
  assign reload  = reload_value(spawn_count);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_cd    = 1'b0;
    dec_cd     = 1'b0;
    fire_go    = 1'b0;
    count_inc  = 1'b0;
    case (state)
      IDLE: begin
        load_cd = 1'b1;
        if (enable) begin
          next_state = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (cd_cnt == 8'd0) begin
          if (!obstacle_active) begin
            next_state = PICK;
          end
        end else if (frame_tick) begin
          dec_cd = 1'b1;
        end
      end
      PICK: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (lane_ok) begin
          fire_go    = 1'b1;
          next_state = FIRE;
        end
      end
      FIRE: begin
        // The pulse is already on the output; it completes even if enable drops.
        count_inc  = 1'b1;
        load_cd    = 1'b1;
        next_state = enable ? COOLDOWN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lfsr             <= SEED_SAFE;
      cd_cnt           <= 8'(COOLDOWN_FRAMES);
      obstacle_trigger <= 2'd0;
      obstacle_start_x <= 10'd0;
      spawn_count      <= 8'd0;
    end else begin
      lfsr             <= lfsr_next(lfsr);
      obstacle_trigger <= fire_go ? typ : 2'd0;
      if (fire_go) begin
        obstacle_start_x <= lane_x;
      end
      if (count_inc) begin
        spawn_count <= sat_inc(spawn_count);
      end
      if (load_cd) begin
        cd_cnt <= reload;
      end else if (dec_cd) begin
        cd_cnt <= cd_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized and directed bench for obstacle_spawner against a cycle-level
// behavioural model of the spawn rules.
module tb_obstacle_spawner;

  localparam int          NL    = 5;
  localparam int          PITCH = 128;
  localparam int          OFF   = 48;
  localparam int          CD    = 60;
  localparam int          MINCD = 15;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       frame_tick;
  logic       obstacle_active;
  logic [1:0] trig;
  logic [9:0] start_x;
  logic [7:0] count;

  always #5 clk = ~clk;

  obstacle_spawner #(
    .NUM_LANES(NL), .LANE_PITCH(PITCH), .LANE_OFFSET(OFF),
    .COOLDOWN_FRAMES(CD), .MIN_COOLDOWN(MINCD), .SEED(SEED)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (reset_n),
    .enable          (enable),
    .frame_tick      (frame_tick),
    .obstacle_active (obstacle_active),
    .obstacle_trigger(trig),
    .obstacle_start_x(start_x),
    .spawn_count     (count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_trig = 0;
  logic [1:0] prev_trig = 2'd0;

  // Model: mode 0 waiting for enable, 1 counting frames, 2 choosing lane, 3 firing.
  int m_mode, m_left, m_count, m_trig, m_x, m_lfsr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int reload_ref(input int c);
    int r;
    r = CD - c / 4;
    return (r < MINCD) ? MINCD : r;
  endfunction

  function automatic int lfsr_adv(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = CD; m_count = 0; m_trig = 0; m_x = 0; m_lfsr = SEED;
  endtask

  task automatic model_step();
    int lane, typ, rl;
    lane = m_lfsr & 7;
    typ  = (m_lfsr >> 3) & 3;
    if (typ == 0) typ = 1;
    rl = reload_ref(m_count);
    m_trig = 0;
    case (m_mode)
      0: begin
        m_left = rl;
        if (enable) m_mode = 1;
      end
      1: begin
        if (!enable) m_mode = 0;
        else if (m_left == 0) begin
          if (!obstacle_active) m_mode = 2;
        end else if (frame_tick) m_left = m_left - 1;
      end
      2: begin
        if (!enable) m_mode = 0;
        else if (lane < NL) begin
          m_trig = typ;
          m_x    = OFF + lane * PITCH;
          m_mode = 3;
        end
      end
      default: begin
        m_left  = rl;
        m_count = (m_count >= 255) ? 255 : m_count + 1;
        m_mode  = enable ? 1 : 0;
      end
    endcase
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("trigger", trig, m_trig);
    chk("start_x", start_x, m_x);
    chk("spawn_count", count, m_count);
    if (trig != 2'd0) begin
      n_trig++;
      chk("pulse_width", prev_trig, 0);
      chk("x_in_lane_set", (start_x inside {10'd48, 10'd176, 10'd304, 10'd432, 10'd560}), 1);
    end
    prev_trig = trig;
  endtask

  // Cooldown probe: r-1 frames must not spawn, the r-th must. Optional hold on expiry.
  task automatic probe(input int r, input int exp_cnt, input bit hold);
    int base;
    bit found;
    frame_tick = 1'b0;
    cycle();
    chk("probe_count", count, exp_cnt);
    base = n_trig;
    frame_tick = 1'b1;
    repeat (r - 1) cycle();
    frame_tick = 1'b0;
    repeat (30) cycle();
    chk("early_trigger", n_trig - base, 0);
    if (hold) begin
      obstacle_active = 1'b1;
      frame_tick = 1'b1;
      repeat (10) cycle();
      frame_tick = 1'b0;
      repeat (3) cycle();
      chk("hold_trigger", n_trig - base, 0);
      obstacle_active = 1'b0;
    end else begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
    end
    found = (trig != 2'd0);
    for (int k = 0; k < 60 && !found; k++) begin
      cycle();
      found = (trig != 2'd0);
    end
    chk("expire_trigger", found, 1);
  endtask

  // Free-running spawns until a trigger shows the wanted count and/or total.
  task automatic run_until(input int want_count, input int want_trigs);
    bit reached;
    enable = 1'b1; obstacle_active = 1'b0; frame_tick = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 30000 && !reached; i++) begin
      cycle();
      if (trig != 2'd0 && (want_count < 0 || m_count == want_count) &&
          (want_trigs < 0 || n_trig >= want_trigs)) reached = 1'b1;
    end
    chk("run_reached", reached, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, summary not produced");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; obstacle_active = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_trigger", trig, 0);
    chk("reset_start_x", start_x, 0);
    chk("reset_count", count, 0);
    reset_n = 1'b1;
    enable = 1'b1;

    probe(reload_ref(0), 0, 1'b0);
    probe(reload_ref(1), 1, 1'b1);
    run_until(8, -1);
    probe(reload_ref(8), 9, 1'b0);

    // Enable drop mid-cooldown, then a full reload after re-enable.
    frame_tick = 1'b0;
    cycle();
    frame_tick = 1'b1;
    repeat (5) cycle();
    begin
      int base;
      base = n_trig;
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
        frame_tick = 1'($urandom_range(0, 1));
        cycle();
      end
      chk("drop_no_trigger", n_trig - base, 0);
      chk("drop_count", count, 10);
    end
    enable = 1'b1;
    probe(reload_ref(10), 10, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      enable          = ($urandom_range(0, 15) != 0);
      frame_tick      = 1'($urandom_range(0, 1));
      obstacle_active = ($urandom_range(0, 3) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of a trigger pulse.
    run_until(-1, n_trig + 1);
    reset_n = 1'b0;
    #1;
    chk("async_trigger", trig, 0);
    chk("async_start_x", start_x, 0);
    chk("async_count", count, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    prev_trig = 2'd0;
    reset_n = 1'b1;
    enable = 1'b1; obstacle_active = 1'b0;
    probe(reload_ref(0), 0, 1'b0);

    run_until(180, -1);
    probe(reload_ref(180), 181, 1'b0);
    run_until(200, -1);
    probe(reload_ref(200), 201, 1'b0);
    run_until(255, -1);
    probe(reload_ref(255), 255, 1'b0);
    run_until(-1, n_trig + 5);
    chk("sat_count", count, 255);
    run_until(-1, (n_trig < 950) ? 1000 : n_trig + 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
